// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: issues sequential AXI-lite reads ahead of the IDU and buffers the
// returned words in an in-order queue; redirects flush the queue and drop stale responses.
module ifu_prefetch #(
   parameter int unsigned       ADDR_W          = 32,
   parameter int unsigned       DATA_W          = 32,
   parameter logic [ADDR_W-1:0] RESET_PC        = 32'h8000_0000,
   parameter int unsigned       FIFO_DEPTH      = 4,
   parameter int unsigned       MAX_OUTSTANDING = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic              rvalid,
   input  logic [1:0]        rresp,
   output logic              rready,
   output logic              ifu_send_valid,
   input  logic              ifu_receive_ready,
   output logic [DATA_W-1:0] instruction,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_err
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   // Two spare bits so inflight+discard and inflight+count never wrap.
   localparam int unsigned CNT_W = PTR_W + 2;

   localparam logic [CNT_W-1:0]  MAX_OUT    = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0]  DEPTH      = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
   localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   logic [DATA_W-1:0] q_inst [FIFO_DEPTH];
   logic [ADDR_W-1:0] q_pc   [FIFO_DEPTH];
   logic              q_err  [FIFO_DEPTH];

   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count, inflight, discard;
   logic [ADDR_W-1:0] fetch_pc, resp_pc;
   logic              halted, ar_stale;

   logic              ar_acc, r_acc, r_keep, r_err, pop, issue;
   logic [CNT_W-1:0]  inflight_nxt, discard_nxt;

   assign ifu_send_valid = (count != '0);

   // NOTE: every always_comb output gets a default before any conditional update; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      ar_acc       = arvalid && arready;
      r_acc        = rvalid && rready;
      r_keep       = r_acc && (discard == '0);
      r_err        = r_keep && (rresp != 2'b00);
      pop          = ifu_send_valid && ifu_receive_ready;
      inflight_nxt = inflight;
      discard_nxt  = discard;
      // An AR that was pending across a redirect belongs to the old stream.
      if (ar_acc && !ar_stale)      inflight_nxt = inflight_nxt + CNT_ONE;
      if (ar_acc && ar_stale)       discard_nxt  = discard_nxt + CNT_ONE;
      if (r_keep)                   inflight_nxt = inflight_nxt - CNT_ONE;
      if (r_acc && discard != '0)   discard_nxt  = discard_nxt - CNT_ONE;
      issue = !arvalid && !halted && !r_err && !redirect_valid
              && ((inflight + discard) < MAX_OUT)
              && ((inflight + count) < DEPTH);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rready   <= 1'b0;
         arvalid  <= 1'b0;
         araddr   <= '0;
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         discard  <= '0;
         halted   <= 1'b0;
         ar_stale <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         rready <= 1'b1;

         if (ar_acc) begin
            arvalid <= 1'b0;
         end else if (issue) begin
            arvalid <= 1'b1;
            araddr  <= fetch_pc;
         end

         if (redirect_valid) begin
            fetch_pc <= redirect_pc & ALIGN_MASK;
            resp_pc  <= redirect_pc & ALIGN_MASK;
            halted   <= 1'b0;
            inflight <= '0;
            discard  <= discard_nxt + inflight_nxt;
            ar_stale <= arvalid && !arready;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (ar_acc && !ar_stale) fetch_pc <= fetch_pc + PC_STEP;
            if (ar_acc)              ar_stale <= 1'b0;
            if (r_keep)              resp_pc  <= resp_pc + PC_STEP;
            if (r_err)               halted   <= 1'b1;
            if (r_keep)              wr_ptr   <= wr_ptr + PTR_ONE;
            if (pop)                 rd_ptr   <= rd_ptr + PTR_ONE;
            inflight <= inflight_nxt;
            discard  <= discard_nxt;
            count    <= count + (r_keep ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
         end
      end
   end

   // NOTE: queue storage has no reset; the outputs are gated by ifu_send_valid, so stale
   // contents are never visible.
   always_ff @(posedge clk) begin
      if (r_keep) begin
         q_inst[wr_ptr] <= r_err ? '0 : rdata;
         q_pc[wr_ptr]   <= resp_pc;
         q_err[wr_ptr]  <= r_err;
      end
   end

   assign instruction = ifu_send_valid ? q_inst[rd_ptr] : '0;
   assign inst_pc     = ifu_send_valid ? q_pc[rd_ptr]   : '0;
   assign inst_err    = ifu_send_valid ? q_err[rd_ptr]  : 1'b0;

endmodule
